// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared encodings for the PC sequencer: PC-source selects,
//                opcode/funct constants, FSM states, vector codes, MEM_LAT.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        C_PCSRC_ALU    = 3'b000,
        C_PCSRC_ALUOUT = 3'b001,
        C_PCSRC_JUMP   = 3'b010,
        C_PCSRC_REG    = 3'b011,
        C_PCSRC_MDR    = 3'b100,
        C_PCSRC_EPC    = 3'b101,
        C_PCSRC_ZERO   = 3'b110
    } pcsrc_e;

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_DEC = 3'd2,
        ST_EXEC     = 3'd3,
        ST_EXC_EPC  = 3'd4,
        ST_EXC_MEM  = 3'd5,
        ST_EXC_JUMP = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        C_VEC_NONE  = 2'b00,
        C_VEC_UNDEF = 2'b01,
        C_VEC_OVF   = 2'b10,
        C_VEC_DIV0  = 2'b11
    } vec_e;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned CNT_W   = $clog2(MEM_LAT + 1);

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_BLE   = 6'h06;
    localparam logic [5:0] C_OP_BGT   = 6'h07;

    localparam logic [5:0] C_FN_JR    = 6'h08;
    localparam logic [5:0] C_FN_RTE   = 6'h13;

    // I-type ALU and load/store opcodes: defined, but never touch the PC
    function automatic logic is_plain_op(input logic [5:0] op);
        case (op)
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h23, 6'h2B: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    // R-type functs other than jr/rte that the datapath implements
    function automatic logic is_known_funct(input logic [5:0] fn);
        case (fn)
            6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Instruction/flag inputs and PC control outputs of the
//                sequencer. master = datapath side, slave = sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic       instr_valid;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_gt;
    logic       exc_overflow;
    logic       exc_div0;
    logic [2:0] pc_source;
    logic       pc_write;
    logic       epc_write;
    logic       mem_read;
    logic [1:0] exc_vec;
    logic       busy;

    modport master (
        output instr_valid, opcode, funct, alu_zero, alu_gt, exc_overflow, exc_div0,
        input  pc_source, pc_write, epc_write, mem_read, exc_vec, busy
    );

    modport slave (
        input  instr_valid, opcode, funct, alu_zero, alu_gt, exc_overflow, exc_div0,
        output pc_source, pc_write, epc_write, mem_read, exc_vec, busy
    );
endinterface
`default_nettype wire

// File: rtl/pc_branch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : pc_branch_decode
//  Description : Combinational classification of the latched instruction into
//                taken branch / jump / jr / rte / undefined.
//                PC_SEQUENCER_RTE_EN: funct 0x13 decodes as rte, else undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_decode
    import pc_sequencer_pkg::*;
(
    input  wire logic [5:0] i_opcode,
    input  wire logic [5:0] i_funct,
    input  wire logic       i_alu_zero,
    input  wire logic       i_alu_gt,
    output logic            o_br_taken,
    output logic            o_jump,
    output logic            o_jr,
    output logic            o_rte,
    output logic            o_undef
);

    always_comb begin
        o_br_taken = 1'b0;
        o_jump     = 1'b0;
        o_jr       = 1'b0;
        o_rte      = 1'b0;
        o_undef    = 1'b0;
        case (i_opcode)
            C_OP_RTYPE: begin
                if (i_funct == C_FN_JR) begin
                    o_jr = 1'b1;
`ifdef PC_SEQUENCER_RTE_EN
                end else if (i_funct == C_FN_RTE) begin
                    o_rte = 1'b1;
`endif
                end else if (!is_known_funct(i_funct)) begin
                    o_undef = 1'b1;
                end
            end
            C_OP_J, C_OP_JAL: o_jump     = 1'b1;
            C_OP_BEQ:         o_br_taken = i_alu_zero;
            C_OP_BNE:         o_br_taken = !i_alu_zero;
            C_OP_BLE:         o_br_taken = !i_alu_gt;
            C_OP_BGT:         o_br_taken = i_alu_gt;
            default:          o_undef    = !is_plain_op(i_opcode);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Multi-cycle PC sequencer with prioritised exception entry
//                (EPC save, vector fetch of MEM_LAT cycles, vector jump).
//                PC_SEQUENCER_RTE_EN: enables rte (R-type funct 0x13).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    pc_sequencer_if.slave bus
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    vec_e             r_exc_vec;

    logic   w_br_taken, w_jump, w_jr, w_rte, w_undef;
    vec_e   w_exc_code;
    logic   w_exc_take;
    pcsrc_e w_src;

    pc_branch_decode u_decode (
        .i_opcode   (r_opcode),
        .i_funct    (r_funct),
        .i_alu_zero (bus.alu_zero),
        .i_alu_gt   (bus.alu_gt),
        .o_br_taken (w_br_taken),
        .o_jump     (w_jump),
        .o_jr       (w_jr),
        .o_rte      (w_rte),
        .o_undef    (w_undef)
    );

    always_comb begin
        if (bus.exc_div0)          w_exc_code = C_VEC_DIV0;
        else if (bus.exc_overflow) w_exc_code = C_VEC_OVF;
        else if (w_undef)          w_exc_code = C_VEC_UNDEF;
        else                       w_exc_code = C_VEC_NONE;
    end

    assign w_exc_take = (r_state == ST_EXEC) && (w_exc_code != C_VEC_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_BOOT;
            r_cnt     <= '0;
            r_opcode  <= '0;
            r_funct   <= '0;
            r_exc_vec <= C_VEC_NONE;
        end else begin
            case (r_state)
                ST_BOOT:  r_state <= ST_FETCH;
                ST_FETCH: r_state <= ST_WAIT_DEC;
                ST_WAIT_DEC: begin
                    if (bus.instr_valid) begin
                        r_opcode <= bus.opcode;
                        r_funct  <= bus.funct;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_exc_take) begin
                        r_exc_vec <= w_exc_code;
                        r_state   <= ST_EXC_EPC;
                    end else begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_EXC_EPC: begin
                    r_cnt   <= CNT_W'(MEM_LAT - 1);
                    r_state <= ST_EXC_MEM;
                end
                ST_EXC_MEM: begin
                    if (r_cnt == '0) r_state <= ST_EXC_JUMP;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end
                ST_EXC_JUMP: begin
                    r_exc_vec <= C_VEC_NONE;
                    r_state   <= ST_FETCH;
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    // Strobes are decoded from state and masked by reset so they drop the
    // instant reset rises rather than at the next edge.
    always_comb begin
        w_src         = C_PCSRC_ALU;
        bus.pc_write  = 1'b0;
        bus.epc_write = 1'b0;
        bus.mem_read  = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_BOOT: begin
                    w_src        = C_PCSRC_ZERO;
                    bus.pc_write = 1'b1;
                end
                ST_FETCH: bus.pc_write = 1'b1;
                ST_EXEC: begin
                    if (!w_exc_take) begin
                        if (w_br_taken) begin
                            w_src        = C_PCSRC_ALUOUT;
                            bus.pc_write = 1'b1;
                        end else if (w_jump) begin
                            w_src        = C_PCSRC_JUMP;
                            bus.pc_write = 1'b1;
                        end else if (w_jr) begin
                            w_src        = C_PCSRC_REG;
                            bus.pc_write = 1'b1;
                        end else if (w_rte) begin
                            w_src        = C_PCSRC_EPC;
                            bus.pc_write = 1'b1;
                        end
                    end
                end
                ST_EXC_EPC: bus.epc_write = 1'b1;
                ST_EXC_MEM: bus.mem_read  = 1'b1;
                ST_EXC_JUMP: begin
                    w_src        = C_PCSRC_MDR;
                    bus.pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_source = w_src;
    assign bus.exc_vec   = r_exc_vec;
    assign bus.busy      = (r_state != ST_WAIT_DEC);

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: instr_valid  in  1  one-cycle strobe: instruction register holds a decoded instruction.
REQ-004 SHALL have port: opcode  in  6  instruction bits [31:26], sampled on instr_valid.
REQ-005 SHALL have port: funct  in  6  instruction bits [5:0], sampled on instr_valid.
REQ-006 SHALL have port: alu_zero, alu_gt  in  1 each  ALU compare flags, sampled in EXEC.
REQ-007 SHALL have port: exc_overflow, exc_div0  in  1 each  exception flags, sampled in EXEC.
REQ-008 SHALL have port: pc_source  out  3  select for the PC-source mux.
REQ-009 SHALL have port: pc_write  out  1  PC load enable.
REQ-010 SHALL have port: epc_write  out  1  EPC load enable.
REQ-011 SHALL have port: mem_read  out  1  memory read request for the exception vector.
REQ-012 SHALL have port: exc_vec  out  2  vector select: 01=253, 10=254, 11=255, 00=none.
REQ-013 SHALL have port: busy  out  1  high in every state except WAIT_DEC.

Function
REQ-014 pc_source encoding SHALL be: 000 ALU result (PC+4), 001 ALUOut (branch target), 010 jump target, 011 register (jr), 100 MDR (vector), 101 EPC, 110 zero; 111 SHALL never be driven.
REQ-015 States SHALL be BOOT, FETCH, WAIT_DEC, EXEC, EXC_EPC, EXC_MEM, EXC_JUMP.
REQ-016 BOOT: pc_source=110, pc_write=1 for one cycle -> FETCH.
REQ-017 FETCH: pc_source=000, pc_write=1 for one cycle -> WAIT_DEC.
REQ-018 WAIT_DEC: all enables 0; on instr_valid latch opcode/funct -> EXEC next cycle.
REQ-019 EXEC, one cycle, -> FETCH unless an exception is taken: beq (0x04) with alu_zero=1, bne (0x05) with alu_zero=0, ble (0x06) with alu_gt=0, bgt (0x07) with alu_gt=1 -> pc_source=001, pc_write=1.
REQ-020 EXEC: j (0x02), jal (0x03) -> 010, pc_write=1; R-type (0x00) funct 0x08 (jr) -> 011, pc_write=1.
REQ-021 EXEC: untaken branch or any other defined opcode -> pc_write=0.
REQ-022 Exception priority in EXEC SHALL be exc_div0 (vec 11) > exc_overflow (vec 10) > undefined opcode/funct (vec 01); a taken exception SHALL suppress pc_write in EXEC and go to EXC_EPC.
REQ-023 EXC_EPC: epc_write=1 for one cycle -> EXC_MEM.
REQ-024 EXC_MEM: mem_read=1 and exc_vec held for exactly MEM_LAT (=2) cycles via down-counter -> EXC_JUMP.
REQ-025 EXC_JUMP: pc_source=100, pc_write=1 for one cycle; exc_vec cleared on exit -> FETCH.
REQ-026 Exception flags and instr_valid SHALL be ignored outside EXEC and WAIT_DEC respectively.
REQ-027 Idle outputs: pc_source=000 and all enables 0 whenever not stated otherwise.

Reset
REQ-028 Asserting reset at any time, including mid-exception, SHALL force state=BOOT, counter=0, latched opcode/funct=0, exc_vec=00 and all enables 0 immediately.
REQ-029 First cycle after reset release SHALL be BOOT.

Configuration
REQ-030 Macro PC_SEQUENCER_RTE_EN defined: R-type funct 0x13 (rte) in EXEC SHALL drive pc_source=101, pc_write=1; undefined: funct 0x13 SHALL raise the undefined-opcode exception (vec 01).

Structure
REQ-031 A shared package SHALL hold the pc_source encodings, opcode/funct constants, state encoding, vector codes and MEM_LAT.
REQ-032 Instruction classification (taken/jump/undefined) SHALL be a sub-module pc_branch_decode, purely combinational; the FSM and counter remain in pc_sequencer.

Verification
REQ-033 Reset release -> BOOT cycle pc_source=110 pc_write=1, next cycle FETCH pc_source=000 pc_write=1, then WAIT_DEC busy=0.
REQ-034 instr_valid, opcode=0x04, alu_zero=1 in EXEC -> pc_source=001 pc_write=1; repeat with alu_zero=0 -> pc_write=0.
REQ-035 opcode=0x00 funct=0x20, exc_overflow=1 and exc_div0=1 in EXEC -> epc_write=1 next cycle, exc_vec=11 with mem_read=1 for 2 cycles, then pc_source=100 pc_write=1, then FETCH.
REQ-036 opcode=0x3F -> exc_vec=01 sequence; opcode=0x00 funct=0x13 -> pc_source=101 with PC_SEQUENCER_RTE_EN, exc_vec=01 without.
REQ-037 reset asserted in first EXC_MEM cycle -> mem_read, exc_vec cleared asynchronously, BOOT after release.
